// File: rtl/chess_clock_ctrl.sv
// Chess clock game controller: turn sequencing, win detection, move count and reload request.
// Optional arbiter pause feature is enabled by defining CHESS_CLOCK_PAUSE_EN.
module chess_clock_ctrl #(
    parameter int p_init_hi = 5,
    parameter int p_init_lo = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_turn_a,
    input  logic            i_turn_b,
    input  logic            i_zero_a,
    input  logic            i_zero_b,
    input  logic            i_pause,
    output logic [1:0][3:0] o_init_a,
    output logic [1:0][3:0] o_init_b,
    output logic            o_stop_a,
    output logic            o_stop_b,
    output logic            o_win_a,
    output logic            o_win_b,
    output logic            o_reload,
    output logic [7:0]      o_moves,
    output logic [2:0]      o_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN_A = 3'd1,
        RUN_B = 3'd2,
        OVER  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       win_a, win_a_nxt;
    logic       win_b, win_b_nxt;
    logic       reload, reload_nxt;
    logic [7:0] moves, moves_nxt;
    logic [7:0] moves_inc;

`ifdef CHESS_CLOCK_PAUSE_EN
    // Remembers which side was running when the arbiter paused the game.
    logic paused_b, paused_b_nxt;
`else
    logic unused_pause;
    assign unused_pause = i_pause;
`endif

    assign o_init_a = {4'(p_init_hi), 4'(p_init_lo)};
    assign o_init_b = {4'(p_init_hi), 4'(p_init_lo)};

    assign moves_inc = (moves == 8'hFF) ? moves : moves + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            win_a  <= 1'b0;
            win_b  <= 1'b0;
            reload <= 1'b0;
            moves  <= 8'd0;
`ifdef CHESS_CLOCK_PAUSE_EN
            paused_b <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            win_a  <= win_a_nxt;
            win_b  <= win_b_nxt;
            reload <= reload_nxt;
            moves  <= moves_nxt;
`ifdef CHESS_CLOCK_PAUSE_EN
            paused_b <= paused_b_nxt;
`endif
        end
    end

    // A running player's own zero flag wins over any same-cycle click.
    always_comb begin
        state_nxt  = state;
        win_a_nxt  = win_a;
        win_b_nxt  = win_b;
        reload_nxt = 1'b0;
        moves_nxt  = moves;
`ifdef CHESS_CLOCK_PAUSE_EN
        paused_b_nxt = paused_b;
`endif
        case (state)
            IDLE: begin
                if (i_turn_a && !i_turn_b) begin
                    state_nxt = RUN_B;
                end else if (i_turn_b && !i_turn_a) begin
                    state_nxt = RUN_A;
                end
            end
            RUN_A: begin
                if (i_zero_a) begin
                    state_nxt = OVER;
                    win_b_nxt = 1'b1;
`ifdef CHESS_CLOCK_PAUSE_EN
                end else if (i_pause) begin
                    state_nxt    = PAUSE;
                    paused_b_nxt = 1'b0;
`endif
                end else if (i_turn_a) begin
                    state_nxt = RUN_B;
                    moves_nxt = moves_inc;
                end
            end
            RUN_B: begin
                if (i_zero_b) begin
                    state_nxt = OVER;
                    win_a_nxt = 1'b1;
`ifdef CHESS_CLOCK_PAUSE_EN
                end else if (i_pause) begin
                    state_nxt    = PAUSE;
                    paused_b_nxt = 1'b1;
`endif
                end else if (i_turn_b) begin
                    state_nxt = RUN_A;
                    moves_nxt = moves_inc;
                end
            end
            OVER: begin
                if (i_turn_a && i_turn_b) begin
                    state_nxt  = IDLE;
                    reload_nxt = 1'b1;
                    win_a_nxt  = 1'b0;
                    win_b_nxt  = 1'b0;
                    moves_nxt  = 8'd0;
                end
            end
`ifdef CHESS_CLOCK_PAUSE_EN
            PAUSE: begin
                if (i_pause) begin
                    state_nxt = paused_b ? RUN_B : RUN_A;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign o_stop_a = (state != RUN_A);
    assign o_stop_b = (state != RUN_B);
    assign o_win_a  = win_a;
    assign o_win_b  = win_b;
    assign o_reload = reload;
    assign o_moves  = moves;
    assign o_state  = state;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed self-checking bench for chess_clock_ctrl; pause checks follow CHESS_CLOCK_PAUSE_EN.
module tb_chess_clock_ctrl;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            i_turn_a = 1'b0;
    logic            i_turn_b = 1'b0;
    logic            i_zero_a = 1'b0;
    logic            i_zero_b = 1'b0;
    logic            i_pause = 1'b0;
    logic [1:0][3:0] o_init_a;
    logic [1:0][3:0] o_init_b;
    logic            o_stop_a;
    logic            o_stop_b;
    logic            o_win_a;
    logic            o_win_b;
    logic            o_reload;
    logic [7:0]      o_moves;
    logic [2:0]      o_state;

    int checkCount = 0;
    int errorCount = 0;

    chess_clock_ctrl #(.p_init_hi(5), .p_init_lo(0)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_turn_a (i_turn_a),
        .i_turn_b (i_turn_b),
        .i_zero_a (i_zero_a),
        .i_zero_b (i_zero_b),
        .i_pause  (i_pause),
        .o_init_a (o_init_a),
        .o_init_b (o_init_b),
        .o_stop_a (o_stop_a),
        .o_stop_b (o_stop_b),
        .o_win_a  (o_win_a),
        .o_win_b  (o_win_b),
        .o_reload (o_reload),
        .o_moves  (o_moves),
        .o_state  (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Hold the given inputs across one rising edge, then release and settle.
    task automatic applyStimulus(input logic rst, input logic ta, input logic tb,
                                 input logic za, input logic zb, input logic p);
        i_rst = rst; i_turn_a = ta; i_turn_b = tb; i_zero_a = za; i_zero_b = zb; i_pause = p;
        @(posedge i_clk);
        #1;
        i_rst = 0; i_turn_a = 0; i_turn_b = 0; i_zero_a = 0; i_zero_b = 0; i_pause = 0;
    endtask

    task automatic checkCore(input string tag, input int st, input int sa, input int sb,
                             input int wa, input int wb, input int mv);
        checkOutput({tag, "_state"}, 32'(o_state), 32'(st));
        checkOutput({tag, "_stop_a"}, 32'(o_stop_a), 32'(sa));
        checkOutput({tag, "_stop_b"}, 32'(o_stop_b), 32'(sb));
        checkOutput({tag, "_win_a"}, 32'(o_win_a), 32'(wa));
        checkOutput({tag, "_win_b"}, 32'(o_win_b), 32'(wb));
        checkOutput({tag, "_moves"}, 32'(o_moves), 32'(mv));
    endtask

    initial begin
        applyStimulus(1, 1, 1, 1, 1, 1);
        checkCore("reset", 0, 1, 1, 0, 0, 0);
        checkOutput("reset_reload", 32'(o_reload), 32'd0);
        checkOutput("init_a", 32'(o_init_a), 32'h50);
        checkOutput("init_b", 32'(o_init_b), 32'h50);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkCore("idle_turn_a", 2, 1, 0, 0, 0, 0);

        applyStimulus(0, 0, 1, 0, 0, 0);
        checkCore("runb_turn_b", 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkCore("runa_turn_b_ignored", 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkCore("runa_zero_b_ignored", 1, 0, 1, 0, 0, 1);

        applyStimulus(0, 1, 0, 1, 0, 0);
        checkCore("runa_zero_a_prio", 3, 1, 1, 0, 1, 1);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkCore("over_single_click", 3, 1, 1, 0, 1, 1);
        checkOutput("over_single_reload", 32'(o_reload), 32'd0);

        applyStimulus(0, 1, 1, 0, 0, 0);
        checkCore("over_both_click", 0, 1, 1, 0, 0, 0);
        checkOutput("over_both_reload", 32'(o_reload), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("reload_one_cycle", 32'(o_reload), 32'd0);

        applyStimulus(0, 1, 1, 0, 0, 0);
        checkCore("idle_both_ignored", 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        checkCore("idle_zero_ignored", 0, 1, 1, 0, 0, 0);

        applyStimulus(0, 0, 1, 0, 0, 0);
        checkCore("idle_turn_b", 1, 0, 1, 0, 0, 0);

`ifdef CHESS_CLOCK_PAUSE_EN
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkCore("pause_enter", 4, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkCore("pause_turn_ignored", 4, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkCore("pause_zero_ignored", 4, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkCore("pause_resume_a", 1, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkCore("pause_from_b", 4, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkCore("pause_resume_b", 2, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkCore("back_to_run_a", 1, 0, 1, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
`else
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkCore("pause_ignored", 1, 0, 1, 0, 0, 0);
`endif

        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) applyStimulus(0, 1, 0, 0, 0, 0);
            else            applyStimulus(0, 0, 1, 0, 0, 0);
            if (i == 254) checkOutput("moves_255_reached", 32'(o_moves), 32'd255);
        end
        checkCore("moves_saturate", 1, 0, 1, 0, 0, 255);

        applyStimulus(0, 1, 0, 0, 0, 0);
        checkCore("sat_turn", 2, 1, 0, 0, 0, 255);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkCore("runb_zero_a_ignored", 2, 1, 0, 0, 0, 255);
        applyStimulus(0, 0, 1, 0, 1, 0);
        checkCore("runb_zero_b_prio", 3, 1, 1, 1, 0, 255);

        applyStimulus(1, 1, 1, 0, 0, 1);
        checkCore("reset_overrides", 0, 1, 1, 0, 0, 0);
        checkOutput("reset_overrides_reload", 32'(o_reload), 32'd0);

        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 1);
        checkCore("reset_midgame", 0, 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
